// File: rtl/ethernet_transmit_package.sv
// Shared types and defaults for the GMII transmit path.
package ethernet_transmit_package;

  typedef enum logic [1:0] {
    IDLE,
    TRANSMIT,
    GAP
  } tx_state_t;

  localparam int unsigned DEFAULT_INTER_FRAME_GAP = 12;
  localparam int unsigned DEFAULT_FIFO_DEPTH      = 16;
  localparam int unsigned FIFO_WIDTH              = 9;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/gmii_transmit_fifo.sv
// 9-bit synchronous show-ahead FIFO; pointers carry an extra wrap bit.
module gmii_transmit_fifo
  import ethernet_transmit_package::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [FIFO_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [FIFO_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_do_wr;
  logic                  w_do_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd   = i_rd_en & ~o_empty;
  // A read in the same cycle frees the slot, so a write at full is still taken.
  assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/gmii_transmitter.sv
// Frame gating, lookahead last-byte marking, elastic buffer and GMII output FSM.
module gmii_transmitter
  import ethernet_transmit_package::*;
#(
  parameter int unsigned INTER_FRAME_GAP = DEFAULT_INTER_FRAME_GAP,
  parameter int unsigned FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pll_lock,
  input  logic [7:0]  transmit_data,
  input  logic        transmit_data_valid,
  output logic [7:0]  gmii_transmit_data,
  output logic        gmii_transmit_enable,
  output logic        gmii_transmit_error,
  output logic [15:0] frame_count,
  output logic        overflow
);

  localparam int unsigned GW = $clog2(INTER_FRAME_GAP + 1);

  logic        r_valid_d;
  logic        r_accept;
  logic        r_la_valid;
  logic [7:0]  r_la_data;
  logic        w_frame_start;
  logic        w_frame_ok;

  fifo_entry_t w_wr_entry;
  fifo_entry_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [GW-1:0] r_gap_cnt;
  logic [GW-1:0] w_gap_nxt;
  logic [7:0]  r_txd;
  logic [7:0]  w_txd_nxt;
  logic        r_txen;
  logic        w_txen_nxt;
  logic        r_txer;
  logic        w_txer_nxt;
  logic        w_frame_done;
  logic [15:0] r_frame_count;
  logic        r_overflow;

  // r_valid_d resets high so a frame already in flight at release never looks like a start.
  assign w_frame_start = transmit_data_valid & ~r_valid_d;
  assign w_frame_ok    = w_frame_start ? (enable & pll_lock) : r_accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_d  <= 1'b1;
      r_accept   <= 1'b0;
      r_la_valid <= 1'b0;
      r_la_data  <= '0;
    end else begin
      r_valid_d  <= transmit_data_valid;
      if (w_frame_start) r_accept <= enable & pll_lock;
      r_la_valid <= transmit_data_valid & w_frame_ok;
      r_la_data  <= transmit_data;
    end
  end

  assign w_wr_entry.last = ~transmit_data_valid;
  assign w_wr_entry.data = r_la_data;

  gmii_transmit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_wr_en   (r_la_valid),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_gap_cnt     <= '0;
      r_txd         <= '0;
      r_txen        <= 1'b0;
      r_txer        <= 1'b0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_txd     <= w_txd_nxt;
      r_txen    <= w_txen_nxt;
      r_txer    <= w_txer_nxt;
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      if (r_la_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // A popped last byte goes straight to GAP, also from IDLE, so 1-byte frames need no TRANSMIT cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap_cnt;
    w_pop        = 1'b0;
    w_txd_nxt    = '0;
    w_txen_nxt   = 1'b0;
    w_txer_nxt   = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      IDLE, TRANSMIT: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_txd_nxt  = w_head.data;
          w_txen_nxt = 1'b1;
          if (w_head.last) begin
            w_state_nxt  = GAP;
            w_gap_nxt    = '0;
            w_frame_done = 1'b1;
          end else begin
            w_state_nxt = TRANSMIT;
          end
        end else if (r_state == TRANSMIT) begin
          w_txen_nxt = 1'b1;
          w_txer_nxt = 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == GW'(INTER_FRAME_GAP - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign gmii_transmit_data   = r_txd;
  assign gmii_transmit_enable = r_txen;
  assign gmii_transmit_error  = r_txer;
  assign frame_count          = r_frame_count;
  assign overflow             = r_overflow;

endmodule

// File: tb/tb_gmii_transmitter.sv
// Directed bench for gmii_transmitter; a second instance uses a 4-entry buffer.
module tb_gmii_transmitter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        pll_lock = 1'b0;
  logic [7:0]  tdata = '0;
  logic        valid = 1'b0;

  logic [7:0]  txd, txd4;
  logic        txen, txen4, txer, txer4, ovf, ovf4;
  logic [15:0] fc, fc4;

  gmii_transmitter u_dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .enable               (enable),
    .pll_lock             (pll_lock),
    .transmit_data        (tdata),
    .transmit_data_valid  (valid),
    .gmii_transmit_data   (txd),
    .gmii_transmit_enable (txen),
    .gmii_transmit_error  (txer),
    .frame_count          (fc),
    .overflow             (ovf)
  );

  gmii_transmitter #(
    .FIFO_DEPTH (4)
  ) u_dut4 (
    .clock                (clock),
    .reset_n              (reset_n),
    .enable               (enable),
    .pll_lock             (pll_lock),
    .transmit_data        (tdata),
    .transmit_data_valid  (valid),
    .gmii_transmit_data   (txd4),
    .gmii_transmit_enable (txen4),
    .gmii_transmit_error  (txer4),
    .frame_count          (fc4),
    .overflow             (ovf4)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [9:0] log_mem [0:4095];
  int unsigned idle_viol = 0;
  always @(negedge clock) begin
    if (cyc < 4096) log_mem[cyc] = {txer, txen, txd};
    if (!txen && (txd != 8'h00 || txer)) idle_viol++;
    if (!txen4 && (txd4 != 8'h00 || txer4)) idle_viol++;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid   = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_frame(input logic [7:0] base, input int len, output int unsigned s);
    s = cyc;
    for (int i = 0; i < len; i++) begin
      tdata = base + 8'(i);
      valid = 1'b1;
      if (i == 0) s = cyc;
      tick();
    end
    valid = 1'b0;
    tdata = '0;
  endtask

  function automatic int count_en(input int unsigned a, input int unsigned b);
    int n = 0;
    for (int unsigned i = a; i <= b; i++) n += int'(log_mem[i][8]);
    return n;
  endfunction

  initial begin
    int unsigned s, s2, s3;
    int bad;

    // Reset state
    repeat (2) tick();
    check("rst_txen", {31'd0, txen}, 32'd0);
    check("rst_txd", {24'd0, txd}, 32'd0);
    check("rst_txer", {31'd0, txer}, 32'd0);
    check("rst_fc", {16'd0, fc}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // One 64-byte frame
    enable = 1'b1; pll_lock = 1'b1;
    send_frame(8'h00, 64, s);
    repeat (80) tick();
    check("s1_before", {31'd0, log_mem[s+2][8]}, 32'd0);
    check("s1_first", {22'd0, log_mem[s+3]}, {22'd0, 2'b01, 8'h00});
    check("s1_en_cnt", count_en(s, s + 90), 32'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) if (log_mem[s+3+i] !== {2'b01, 8'(i)}) bad++;
    check("s1_data", bad, 32'd0);
    check("s1_after", {31'd0, log_mem[s+67][8]}, 32'd0);
    check("s1_fc", {16'd0, fc}, 32'd1);

    // Two 60-byte frames, one idle input cycle apart
    do_reset();
    send_frame(8'h00, 60, s);
    tick();
    send_frame(8'h40, 60, s2);
    repeat (40) tick();
    check("s2_a_last", {31'd0, log_mem[s+62][8]}, 32'd1);
    check("s2_gap", count_en(s + 63, s + 74), 32'd0);
    check("s2_b_first", {22'd0, log_mem[s+75]}, {22'd0, 2'b01, 8'h40});
    check("s2_en_cnt", count_en(s, s + 150), 32'd120);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (log_mem[s+3+i] !== {2'b01, 8'(i)}) bad++;
      if (log_mem[s+75+i] !== {2'b01, 8'(8'h40 + i)}) bad++;
    end
    check("s2_data", bad, 32'd0);
    check("s2_ovf", {31'd0, ovf}, 32'd0);
    check("s2_fc", {16'd0, fc}, 32'd2);

    // Frame starting with enable low, then with pll_lock low
    do_reset();
    enable = 1'b0;
    s = cyc;
    for (int i = 0; i < 10; i++) begin
      tdata = 8'h10 + 8'(i);
      valid = 1'b1;
      if (i == 0) s = cyc;
      if (i == 3) enable = 1'b1;
      tick();
    end
    valid = 1'b0;
    repeat (2) tick();
    send_frame(8'h90, 5, s2);
    repeat (20) tick();
    check("s3_discard", count_en(s, s + 14), 32'd0);
    check("s3_next_first", {22'd0, log_mem[s2+3]}, {22'd0, 2'b01, 8'h90});
    check("s3_next_cnt", count_en(s2, s2 + 20), 32'd5);
    bad = 0;
    for (int i = 0; i < 5; i++) if (log_mem[s2+3+i] !== {2'b01, 8'(8'h90 + i)}) bad++;
    check("s3_data", bad, 32'd0);
    pll_lock = 1'b0;
    send_frame(8'h20, 4, s3);
    pll_lock = 1'b1;
    repeat (15) tick();
    check("s3_nolock", count_en(s3, s3 + 15), 32'd0);
    check("s3_fc", {16'd0, fc}, 32'd1);

    // 1-byte frames: exact 12-cycle gap before the next one
    do_reset();
    send_frame(8'hA5, 1, s);
    tick();
    send_frame(8'h5A, 1, s2);
    repeat (25) tick();
    check("s4_before", {31'd0, log_mem[s+2][8]}, 32'd0);
    check("s4_a5", {22'd0, log_mem[s+3]}, {22'd0, 2'b01, 8'hA5});
    check("s4_gap12", count_en(s + 4, s + 15), 32'd0);
    check("s4_5a", {22'd0, log_mem[s+16]}, {22'd0, 2'b01, 8'h5A});
    check("s4_after", {31'd0, log_mem[s+17][8]}, 32'd0);
    check("s4_fc", {16'd0, fc}, 32'd2);

    // Overflow on the 4-entry instance
    do_reset();
    check("s5_ovf4_rst", {31'd0, ovf4}, 32'd0);
    send_frame(8'h00, 8, s);
    tick();
    send_frame(8'h40, 20, s2);
    repeat (40) tick();
    check("s5_ovf4_set", {31'd0, ovf4}, 32'd1);
    check("s5_ovf16", {31'd0, ovf}, 32'd0);
    check("s5_fc4", {16'd0, fc4}, 32'd2);
    repeat (20) tick();
    check("s5_ovf4_sticky", {31'd0, ovf4}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("s5_ovf4_clr", {31'd0, ovf4}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Reset pulsed mid-frame at byte 10
    s = cyc;
    for (int i = 0; i < 30; i++) begin
      tdata = 8'(i);
      valid = 1'b1;
      if (i == 0) s = cyc;
      if (i == 13) reset_n = 1'b1;
      if (i == 10) begin
        reset_n = 1'b0;
        #1;
        check("s6_rst_txen", {31'd0, txen}, 32'd0);
        check("s6_rst_txd", {24'd0, txd}, 32'd0);
        check("s6_rst_txer", {31'd0, txer}, 32'd0);
      end
      tick();
    end
    valid = 1'b0;
    repeat (20) tick();
    check("s6_pre", {22'd0, log_mem[s+3]}, {22'd0, 2'b01, 8'h00});
    check("s6_discard", count_en(s + 11, s + 45), 32'd0);
    check("s6_fc", {16'd0, fc}, 32'd0);
    send_frame(8'h30, 3, s2);
    repeat (20) tick();
    check("s6_next", {22'd0, log_mem[s2+3]}, {22'd0, 2'b01, 8'h30});
    check("s6_fc_next", {16'd0, fc}, 32'd1);

    check("idle_data_zero", idle_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmii_transmitter.md
GMII_TRANSMITTER -- requirements
Module: gmii_transmitter

Interface
REQ-001 SHALL have parameter INTER_FRAME_GAP, default 12, meaning the minimum idle cycles between frames on GMII.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the entry count of the elastic buffer (power of two).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: accept new frames when high.
REQ-006 SHALL have port pll_lock, input, 1 bit: accept new frames only when high.
REQ-007 SHALL have port transmit_data, input, 8 bits: frame byte from ethernet_packet_generator.
REQ-008 SHALL have port transmit_data_valid, input, 1 bit: byte qualifier; a contiguous high run is one frame.
REQ-009 SHALL have port gmii_transmit_data, output, 8 bits: GMII TXD.
REQ-010 SHALL have port gmii_transmit_enable, output, 1 bit: GMII TX_EN.
REQ-011 SHALL have port gmii_transmit_error, output, 1 bit: GMII TX_ER.
REQ-012 SHALL have port frame_count, output, 16 bits: count of frames completed on GMII.
REQ-013 SHALL have port overflow, output, 1 bit: sticky buffer-overflow flag.

Function
REQ-014 SHALL sample enable and pll_lock only on the first valid cycle of a frame (valid rising); if both are high, the whole frame is accepted, otherwise every byte of that frame is discarded, regardless of later changes in enable or pll_lock.
REQ-015 SHALL hold each accepted byte one cycle in a lookahead register and write it to the FIFO with a last flag equal to NOT transmit_data_valid on the following cycle.
REQ-016 SHALL realise a 1-byte frame as a write with last=1.
REQ-017 SHALL implement output states IDLE, TRANSMIT and GAP.
REQ-018 IDLE SHALL move to TRANSMIT when the FIFO is non-empty, popping the head entry.
REQ-019 TRANSMIT SHALL pop one entry per cycle, registering it onto gmii_transmit_data with gmii_transmit_enable=1.
REQ-020 On the pop of an entry with last=1, TRANSMIT SHALL move to GAP.
REQ-021 GAP SHALL hold gmii_transmit_enable low for exactly INTER_FRAME_GAP cycles after the last byte, then move to IDLE.
REQ-022 Latency SHALL be 3 cycles: a first byte presented at cycle N with the FIFO empty and the state IDLE appears on GMII at cycle N+3.
REQ-023 A frame arriving during TRANSMIT or GAP SHALL be buffered and sent back-to-back after the gap, so the earliest first byte is on cycle M+INTER_FRAME_GAP+1 after a last byte at cycle M.
REQ-024 If the FIFO is empty while in TRANSMIT without a last flag seen (underrun), the block SHALL drive gmii_transmit_error=1 and gmii_transmit_enable=1 for that cycle and continue.
REQ-025 If a write occurs while the FIFO is full, the block SHALL drop the byte and set overflow=1; overflow SHALL stay set until reset.
REQ-026 A simultaneous read and write at full SHALL be accepted without overflow.
REQ-027 frame_count SHALL increment by 1 on the cycle the last byte is driven and wrap from 0xFFFF to 0x0000.
REQ-028 gmii_transmit_data SHALL be 0x00 whenever gmii_transmit_enable is 0.

Reset
REQ-029 Assertion of reset_n low SHALL asynchronously force the state to IDLE, empty the FIFO and clear the lookahead register, the gap counter, frame_count and overflow.
REQ-030 While reset_n is low, gmii_transmit_data=0x00, gmii_transmit_enable=0 and gmii_transmit_error=0.
REQ-031 Reset mid-frame SHALL abort the frame; after release, input bytes SHALL be discarded until transmit_data_valid has been low for at least one cycle.
REQ-032 Reset release SHALL be treated as synchronous to clock; no internal synchroniser is required.

Structure
REQ-033 Package ethernet_transmit_package SHALL hold the state enum (IDLE, TRANSMIT, GAP), the default INTER_FRAME_GAP=12 and the default FIFO_DEPTH=16.
REQ-034 The buffer SHALL be a sub-module gmii_transmit_fifo.
REQ-035 gmii_transmit_fifo SHALL be a 9-bit-wide synchronous FIFO with full and empty flags and pointers one bit wider than the address.

Verification
REQ-036 Scenario: one 64-byte frame (0x00..0x3F) with enable=1, pll_lock=1 -> TX_EN high for 64 cycles starting 3 cycles after the first valid, data in order, frame_count=1.
REQ-037 Scenario: two 60-byte frames separated by 1 idle input cycle -> exactly 12 TX_EN-low cycles between them on GMII, overflow=0, frame_count=2.
REQ-038 Scenario: enable=0 at frame start, raised mid-frame -> nothing is transmitted; the next frame started with enable=1 is transmitted normally.
REQ-039 Scenario: 1-byte frame 0xA5 -> a single TX_EN cycle carrying 0xA5, then 12-cycle gap, frame_count increments.
REQ-040 Scenario: FIFO_DEPTH=4 with back-to-back frames forced to exceed the buffer -> overflow=1 and sticky; reset clears it.
REQ-041 Scenario: reset_n pulsed low mid-frame at byte 10 -> outputs 0 immediately; remaining bytes of that frame are not transmitted; frame_count=0.
